// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO stack with separate push/pop strobes (pop+push = replace top).
// Latency: pop data registered, on dout with dout_vld one cycle after the request; top is a combinational peek.
// Backpressure: none; push on full / pop on empty are dropped (sticky ovf/udf when LIFO_STACK_ERR_EN is defined).
module lifo_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   input  logic             err_clr,
   output logic             ovf,
   output logic             udf
);

   // Index width for the storage array; DEPTH need not be a power of two.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_vld;

   logic             w_empty;
   logic             w_full;
   logic             w_push_acc;
   logic             w_pop_acc;
   logic [AW-1:0]    w_top_idx;
   logic [AW-1:0]    w_wr_idx;
   logic [CW-1:0]    w_count_nxt;

   // Status is decoded from the registered count only, so no input reaches an output combinationally.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));

   // A pop needs data; a push is taken unless the stack is full and no pop frees the top slot.
   // Push+pop on an empty stack therefore performs the push and drops the pop.
   assign w_pop_acc  = pop & ~w_empty;
   assign w_push_acc = push & (~w_full | w_pop_acc);

   // Top slot index; wraps when empty, but nothing reads or writes it then.
   assign w_top_idx = AW'(r_count - CW'(1));

   // Replace overwrites the current top; a plain push writes the slot above it.
   assign w_wr_idx = w_pop_acc ? w_top_idx : AW'(r_count);

   // Occupancy moves only when exactly one of the two operations is accepted.
   always_comb begin
      w_count_nxt = r_count;
      if (w_push_acc && !w_pop_acc)
         w_count_nxt = r_count + CW'(1);
      else if (w_pop_acc && !w_push_acc)
         w_count_nxt = r_count - CW'(1);
   end

   // Storage write; the array is deliberately not reset and requests during reset are ignored.
   always_ff @(posedge clk) begin
      if (!rst && w_push_acc)
         r_mem[w_wr_idx] <= din;
   end

   // Occupancy register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else
         r_count <= w_count_nxt;
   end

   // Pop data path: dout holds between pops, dout_vld pulses for each accepted pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout     <= '0;
         r_dout_vld <= 1'b0;
      end else begin
         r_dout_vld <= w_pop_acc;
         if (w_pop_acc)
            r_dout <= r_mem[w_top_idx];
      end
   end

`ifdef LIFO_STACK_ERR_EN
   logic r_ovf;
   logic r_udf;
   logic w_ovf_set;
   logic w_udf_set;

   // A push is only rejected when the stack is full and nothing is popped alongside it.
   assign w_ovf_set = push & ~pop & w_full;
   assign w_udf_set = pop & w_empty;

   // Sticky error flags; a fresh rejection wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (w_ovf_set)
            r_ovf <= 1'b1;
         else if (err_clr)
            r_ovf <= 1'b0;
         if (w_udf_set)
            r_udf <= 1'b1;
         else if (err_clr)
            r_udf <= 1'b0;
      end
   end

   assign ovf = r_ovf;
   assign udf = r_udf;
`else
   // Flag logic removed: outputs tied low, clear input has no effect.
   logic w_unused;
   assign w_unused = &{1'b0, err_clr};
   assign ovf      = 1'b0;
   assign udf      = 1'b0;
`endif

   assign count    = r_count;
   assign empty    = w_empty;
   assign full     = w_full;
   assign dout     = r_dout;
   assign dout_vld = r_dout_vld;
   assign top      = w_empty ? '0 : r_mem[w_top_idx];

endmodule

// File: tb/tb_lifo_stack.sv
module tb_lifo_stack;

   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic             err_clr = 1'b0;
   logic [WIDTH-1:0] dout;
   logic             dout_vld;
   logic [WIDTH-1:0] top;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             ovf;
   logic             udf;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: a queue whose back is the top of stack.
   logic [WIDTH-1:0] m_stk[$];
   logic [WIDTH-1:0] m_dout = '0;
   bit               m_vld = 1'b0;
   bit               m_ovf = 1'b0;
   bit               m_udf = 1'b0;

   lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .din      (din),
      .dout     (dout),
      .dout_vld (dout_vld),
      .top      (top),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .err_clr  (err_clr),
      .ovf      (ovf),
      .udf      (udf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = m_stk.size();
      chk({tag, ".count"}, 32'(count), 32'(sz));
      chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
      chk({tag, ".full"},  32'(full),  32'(sz == DEPTH));
      chk({tag, ".top"},   32'(top),   (sz == 0) ? 32'h0 : 32'(m_stk[sz-1]));
      chk({tag, ".dout"},  32'(dout),  32'(m_dout));
      chk({tag, ".vld"},   32'(dout_vld), 32'(m_vld));
      chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
      chk({tag, ".udf"},   32'(udf),   32'(m_udf));
   endtask

   // Apply one request to the model using the stack rules.
   task automatic model_step(input bit p, input bit q, input logic [WIDTH-1:0] d, input bit c);
      bit ovf_ev, udf_ev;
      ovf_ev = 1'b0;
      udf_ev = 1'b0;
      m_vld  = 1'b0;
      if (q && m_stk.size() > 0) begin
         m_dout = m_stk.pop_back();
         m_vld  = 1'b1;
         if (p) m_stk.push_back(d);
      end else begin
         if (q) udf_ev = 1'b1;
         if (p) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(d);
            else ovf_ev = 1'b1;
         end
      end
`ifdef LIFO_STACK_ERR_EN
      m_ovf = ovf_ev ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_udf = udf_ev ? 1'b1 : (c ? 1'b0 : m_udf);
`else
      if (ovf_ev || udf_ev || c) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end
`endif
   endtask

   task automatic cycle(input string tag, input bit p, input bit q, input logic [WIDTH-1:0] d, input bit c);
      push    = p;
      pop     = q;
      din     = d;
      err_clr = c;
      @(posedge clk);
      #1;
      model_step(p, q, d, c);
      push    = 1'b0;
      pop     = 1'b0;
      err_clr = 1'b0;
      check_all(tag);
   endtask

   task automatic model_reset();
      m_stk.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   initial begin
      // Reset state.
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // Fill with 0x1000..0x100F then drain.
      for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, 16'h1000 + 16'(i), 1'b0);
      chk("full_after_fill", 32'(full), 32'h1);
      for (int i = 0; i < DEPTH; i++) begin
         cycle("drain", 1'b0, 1'b1, '0, 1'b0);
         chk("drain_data", 32'(dout), 32'(16'h100F - 16'(i)));
      end
      chk("empty_after_drain", 32'(empty), 32'h1);

      // Overflow then clear.
      for (int i = 0; i < DEPTH; i++) cycle("refill", 1'b1, 1'b0, 16'($urandom), 1'b0);
      cycle("ovf_push", 1'b1, 1'b0, 16'hBEEF, 1'b0);
      cycle("ovf_clr", 1'b0, 1'b0, '0, 1'b1);
      cycle("full_replace", 1'b1, 1'b1, 16'h5A5A, 1'b0);
      for (int i = 0; i < DEPTH; i++) cycle("empty_out", 1'b0, 1'b1, '0, 1'b0);

      // Underflow, clear racing a new underflow, then push+pop on empty.
      cycle("udf_pop", 1'b0, 1'b1, '0, 1'b0);
      cycle("udf_setwins", 1'b0, 1'b1, '0, 1'b1);
      cycle("udf_clr", 1'b0, 1'b0, '0, 1'b1);
      cycle("pp_empty", 1'b1, 1'b1, 16'h0042, 1'b0);
      chk("pp_empty_top", 32'(top), 32'h0042);

      // Replace top on a two-entry stack.
      cycle("clr_pop", 1'b0, 1'b1, '0, 1'b1);
      cycle("push1", 1'b1, 1'b0, 16'h0001, 1'b0);
      cycle("push2", 1'b1, 1'b0, 16'h0002, 1'b0);
      cycle("replace", 1'b1, 1'b1, 16'h0003, 1'b0);
      chk("replace_dout", 32'(dout), 32'h0002);
      chk("replace_top", 32'(top), 32'h0003);

      // Asynchronous reset in the middle of a push burst.
      for (int i = 0; i < 5; i++) cycle("burst", 1'b1, 1'b0, 16'h2000 + 16'(i), 1'b0);
      cycle("burst_pop", 1'b0, 1'b1, '0, 1'b0);
      push = 1'b1;
      din  = 16'h2222;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      #1;
      check_all("rst_held");
      push = 1'b0;
      #2;
      rst = 1'b0;
      cycle("post_rst", 1'b1, 1'b0, 16'h0007, 1'b0);
      chk("post_rst_top", 32'(top), 32'h0007);

      // Randomised traffic; the bias swings between filling and draining phases.
      for (int i = 0; i < 3000; i++) begin
         int bias;
         bit p, q;
         bias = ((i / 200) % 2 == 0) ? 70 : 30;
         p = ($urandom_range(0, 99) < bias);
         q = ($urandom_range(0, 99) < (100 - bias));
         cycle("rand", p, q, 16'($urandom), ($urandom_range(0, 15) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
